// File: rtl/lfsr_sampler_bank.sv
// rtl/lfsr_sampler_bank.sv - multi-lane Fibonacci LFSR bank with Bernoulli sampler
// Each lane compares its current random word with a threshold on every accepted request.
module lfsr_sampler_bank #(
  parameter int               WIDTH    = 16,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter int               CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] seed,
  input  logic                      load,
  input  logic                      en,
  input  logic                      prob_valid,
  output logic                      prob_ready,
  input  logic [CHANNELS*WIDTH-1:0] prob,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic [CHANNELS-1:0]       sample,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]          sample_count
);

  logic                acc;
  logic                advance;
  logic [CHANNELS-1:0] cmp;

  // One-entry output register: a consumed slot can be refilled in the same cycle.
  assign prob_ready = ~sample_valid | sample_ready;
  assign acc        = prob_valid & prob_ready;
  assign advance    = en | acc;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] nxt;
    logic             fb;

    // The zero-state term kicks an all-zero lane out of the lock-up state.
    assign fb  = (^(s & TAPS)) ^ (s == '0);
    assign nxt = {s[WIDTH-2:0], fb};

    assign cmp[c]                      = s < prob[c*WIDTH +: WIDTH];
    assign data_out[c*WIDTH +: WIDTH]  = s;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s <= seed[c*WIDTH +: WIDTH];
      end else if (load) begin
        s <= seed[c*WIDTH +: WIDTH];
      end else if (advance) begin
        s <= nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_count <= '0;
    end else begin
      if (acc) begin
        sample       <= cmp;
        sample_valid <= 1'b1;
        sample_count <= sample_count + 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_sampler_bank.sv
// tb/tb_lfsr_sampler_bank.sv - directed self-checking bench for lfsr_sampler_bank
// WIDTH=4, CHANNELS=2, TAPS=4'b1100 with hand-computed expected values.
module tb_lfsr_sampler_bank;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int CNT_W    = 32;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] seed;
  logic                      load;
  logic                      en;
  logic                      prob_valid;
  logic                      prob_ready;
  logic [CHANNELS*WIDTH-1:0] prob;
  logic                      sample_valid;
  logic                      sample_ready;
  logic [CHANNELS-1:0]       sample;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [CNT_W-1:0]          sample_count;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_sampler_bank #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .TAPS    (4'b1100),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seed        (seed),
    .load        (load),
    .en          (en),
    .prob_valid  (prob_valid),
    .prob_ready  (prob_ready),
    .prob        (prob),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample      (sample),
    .data_out    (data_out),
    .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq [16];

  initial begin
    seq[0]  = 4'h1; seq[1]  = 4'h2; seq[2]  = 4'h4; seq[3]  = 4'h9;
    seq[4]  = 4'h3; seq[5]  = 4'h6; seq[6]  = 4'hD; seq[7]  = 4'hA;
    seq[8]  = 4'h5; seq[9]  = 4'hB; seq[10] = 4'h7; seq[11] = 4'hF;
    seq[12] = 4'hE; seq[13] = 4'hC; seq[14] = 4'h8; seq[15] = 4'h1;

    reset        = 1'b0;
    seed         = {4'h8, 4'h1};
    load         = 1'b0;
    en           = 1'b0;
    prob_valid   = 1'b0;
    prob         = '0;
    sample_ready = 1'b1;
    #1 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_data_out", 32'(data_out), 32'h81);
    chk("reset_valid", 32'(sample_valid), 32'h0);
    chk("reset_count", sample_count, 32'h0);
    chk("reset_sample", 32'(sample), 32'h0);
    chk("reset_prob_ready", 32'(prob_ready), 32'h1);

    // Full period on both lanes; lane1 starts at index 14 (value 8).
    en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("seq_lane0", 32'(data_out[3:0]), 32'(seq[i]));
      chk("seq_lane1", 32'(data_out[7:4]), 32'(seq[(i + 14) % 15]));
    end
    en = 1'b0;

    // Zero-lock escape
    seed = {4'h8, 4'h0};
    load = 1'b1;
    step();
    load = 1'b0;
    chk("zero_loaded", 32'(data_out[3:0]), 32'h0);
    en = 1'b1;
    step();
    chk("zero_escape", 32'(data_out[3:0]), 32'h1);
    step();
    chk("zero_continue", 32'(data_out[3:0]), 32'h2);
    en = 1'b0;

    // Sampler: 6<7 -> 1, 9<9 -> 0
    seed = {4'h9, 4'h6};
    load = 1'b1;
    step();
    load = 1'b0;
    chk("samp_pre_state", 32'(data_out), 32'h96);
    prob       = {4'h9, 4'h7};
    prob_valid = 1'b1;
    step();
    prob_valid = 1'b0;
    chk("samp_sample", 32'(sample), 32'h1);
    chk("samp_valid", 32'(sample_valid), 32'h1);
    chk("samp_count", sample_count, 32'h1);
    chk("samp_advance", 32'(data_out), 32'h3D);
    step();
    chk("samp_clear", 32'(sample_valid), 32'h0);
    chk("samp_hold_state", 32'(data_out), 32'h3D);

    // Backpressure
    sample_ready = 1'b0;
    load         = 1'b1;
    step();
    load       = 1'b0;
    prob_valid = 1'b1;
    step();
    chk("bp_first_count", sample_count, 32'h2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_prob_ready", 32'(prob_ready), 32'h0);
      chk("bp_sample", 32'(sample), 32'h1);
      chk("bp_data_out", 32'(data_out), 32'h3D);
      chk("bp_count", sample_count, 32'h2);
    end
    sample_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(prob_ready), 32'h1);
    step();
    chk("bp_acc1_sample", 32'(sample), 32'h2);
    chk("bp_acc1_state", 32'(data_out), 32'h6A);
    chk("bp_acc1_count", sample_count, 32'h3);
    step();
    chk("bp_acc2_sample", 32'(sample), 32'h2);
    chk("bp_acc2_state", 32'(data_out), 32'hD5);
    chk("bp_acc2_count", sample_count, 32'h4);
    step();
    chk("bp_acc3_sample", 32'(sample), 32'h1);
    chk("bp_acc3_state", 32'(data_out), 32'hAB);
    chk("bp_acc3_count", sample_count, 32'h5);
    prob_valid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(sample_valid), 32'h0);
    chk("bp_drain_count", sample_count, 32'h5);

    // Load with accept in the same cycle: sample uses pre-load state A/A
    seed = {4'hA, 4'hA};
    load = 1'b1;
    step();
    chk("lp_pre_state", 32'(data_out), 32'hAA);
    seed       = {4'h3, 4'h3};
    prob       = {4'h0, 4'hF};
    prob_valid = 1'b1;
    step();
    load       = 1'b0;
    prob_valid = 1'b0;
    chk("lp_sample", 32'(sample), 32'h1);
    chk("lp_state", 32'(data_out), 32'h33);
    chk("lp_count", sample_count, 32'h6);
    chk("lp_valid", 32'(sample_valid), 32'h1);

    // Build up to count 7 with a pending sample, then reset asynchronously
    prob_valid = 1'b1;
    step();
    prob_valid   = 1'b0;
    sample_ready = 1'b0;
    #1;
    chk("ar_pre_count", sample_count, 32'h7);
    chk("ar_pre_valid", 32'(sample_valid), 32'h1);
    chk("ar_pre_state", 32'(data_out), 32'h66);
    seed  = {4'h5, 4'hC};
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(sample_valid), 32'h0);
    chk("ar_count", sample_count, 32'h0);
    chk("ar_state", 32'(data_out), 32'h5C);
    chk("ar_sample", 32'(sample), 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("ar_prob_ready", 32'(prob_ready), 32'h1);
    chk("ar_state_hold", 32'(data_out), 32'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
